// File: rtl/mem_access_unit_if.sv
// Bus bundle between the EX/MEM stage, the memory access unit and the dcache.
// The slave modport is the access unit; the master modport is its environment.
interface mem_access_unit_if;
    logic        dmemREN_in;
    logic        dmemWEN_in;
    logic        halt_in;
    logic [31:0] aluResult_in;
    logic [31:0] rdat2_in;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        pipe_wen;
    logic [31:0] load_data;
    logic        load_valid;
    logic        halt_out;
    logic        timeout_err;
    logic [15:0] access_count;

    modport slave (
        input  dmemREN_in, dmemWEN_in, halt_in, aluResult_in, rdat2_in, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, pipe_wen, load_data, load_valid,
               halt_out, timeout_err, access_count
    );

    modport master (
        output dmemREN_in, dmemWEN_in, halt_in, aluResult_in, rdat2_in, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, pipe_wen, load_data, load_valid,
               halt_out, timeout_err, access_count
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: latches one load/store from EX/MEM, drives the dcache
// until dhit or timeout, stalls the pipeline meanwhile, and parks in HALTED on halt.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [31:0] hold_addr;
    logic [31:0] hold_data;
    logic        hold_rd;
    logic        hold_wr;
    logic        hold_halt;
    logic [7:0]  wait_cnt;
    logic [31:0] load_data_r;
    logic        timeout_err_r;
    logic [15:0] access_count_r;
    logic        req;
    logic        timeout_hit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign req         = bus.dmemREN_in | bus.dmemWEN_in;
    // The abort fires at the end of the TIMEOUT_CYCLES-th ACCESS cycle without dhit.
    assign timeout_hit = (state == ACCESS) && !bus.dhit && (wait_cnt == WAIT_LAST);

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req)              next_state = ACCESS;
                else if (bus.halt_in) next_state = HALTED;
            end
            ACCESS: begin
                if (bus.dhit || timeout_hit) next_state = DONE;
            end
            DONE:    next_state = hold_halt ? HALTED : IDLE;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_addr      <= '0;
            hold_data      <= '0;
            hold_rd        <= 1'b0;
            hold_wr        <= 1'b0;
            hold_halt      <= 1'b0;
            wait_cnt       <= '0;
            load_data_r    <= '0;
            timeout_err_r  <= 1'b0;
            access_count_r <= '0;
        end else begin
            if (state == IDLE && req) begin
                hold_addr <= bus.aluResult_in;
                hold_data <= bus.rdat2_in;
                hold_rd   <= bus.dmemREN_in;
                // A simultaneous read and write is serviced as the read alone.
                hold_wr   <= bus.dmemWEN_in & ~bus.dmemREN_in;
                hold_halt <= bus.halt_in;
                wait_cnt  <= '0;
            end
            if (state == ACCESS) begin
                if (bus.dhit) begin
                    if (hold_rd) load_data_r <= bus.dmemload;
                    access_count_r <= sat_inc16(access_count_r);
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (timeout_hit) begin
                        load_data_r   <= '0;
                        timeout_err_r <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.dmemREN    = 1'b0;
        bus.dmemWEN    = 1'b0;
        bus.pipe_wen   = 1'b1;
        bus.load_valid = 1'b0;
        bus.halt_out   = 1'b0;
        case (state)
            IDLE: bus.pipe_wen = ~req;
            ACCESS: begin
                bus.dmemREN  = hold_rd;
                bus.dmemWEN  = hold_wr;
                bus.pipe_wen = 1'b0;
            end
            DONE: bus.load_valid = hold_rd;
            HALTED: begin
                bus.pipe_wen = 1'b0;
                bus.halt_out = 1'b1;
            end
            default: bus.pipe_wen = 1'b1;
        endcase
    end

    assign bus.dmemaddr     = hold_addr;
    assign bus.dmemstore    = hold_data;
    assign bus.load_data    = load_data_r;
    assign bus.timeout_err  = timeout_err_r;
    assign bus.access_count = access_count_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected load results go into a queue that a
// negedge monitor drains on every load_valid pulse; control timing is checked inline.
module tb_mem_access_unit;
    logic CLK = 1'b0;
    logic nRST;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    int          ren_cyc = 0;
    int          wen_cyc = 0;
    int          stall_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_counters();
        ren_cyc = 0;
        wen_cyc = 0;
        stall_cyc = 0;
    endtask

    task automatic clr_req();
        bus.dmemREN_in = 1'b0;
        bus.dmemWEN_in = 1'b0;
        bus.halt_in    = 1'b0;
    endtask

    // Monitor: cycle counters plus scoreboard drain on load_valid.
    always @(negedge CLK) begin
        if (bus.dmemREN === 1'b1) ren_cyc++;
        if (bus.dmemWEN === 1'b1) wen_cyc++;
        if (bus.pipe_wen === 1'b0) stall_cyc++;
        if (bus.load_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_valid_unexpected: got pulse with data %h expected no pulse", bus.load_data);
            end else begin
                exp_v = exp_q.pop_front();
                chk("load_data", bus.load_data, exp_v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST             = 1'b0;
        bus.dmemREN_in   = 1'b0;
        bus.dmemWEN_in   = 1'b0;
        bus.halt_in      = 1'b0;
        bus.aluResult_in = '0;
        bus.rdat2_in     = '0;
        bus.dhit         = 1'b0;
        bus.dmemload     = '0;
        repeat (3) step();
        nRST = 1'b1;
        step();
        @(negedge CLK);
        chk("rst_dmemREN",      32'(bus.dmemREN), 0);
        chk("rst_dmemWEN",      32'(bus.dmemWEN), 0);
        chk("rst_dmemaddr",     bus.dmemaddr, 0);
        chk("rst_dmemstore",    bus.dmemstore, 0);
        chk("rst_load_data",    bus.load_data, 0);
        chk("rst_halt_out",     32'(bus.halt_out), 0);
        chk("rst_timeout_err",  32'(bus.timeout_err), 0);
        chk("rst_access_count", 32'(bus.access_count), 0);
        chk("rst_pipe_wen",     32'(bus.pipe_wen), 1);

        // Read with immediate dhit
        step();
        clr_counters();
        bus.dmemREN_in   = 1'b1;
        bus.aluResult_in = 32'h0000_0040;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge CLK);
        chk("rd_pipe_wen_idle_req", 32'(bus.pipe_wen), 0);
        chk("rd_dmemREN_idle", 32'(bus.dmemREN), 0);
        step();
        clr_req();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("rd_dmemREN_access", 32'(bus.dmemREN), 1);
        chk("rd_dmemaddr", bus.dmemaddr, 32'h0000_0040);
        step();
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        @(negedge CLK);
        chk("rd_pipe_wen_done", 32'(bus.pipe_wen), 1);
        chk("rd_access_count", 32'(bus.access_count), 1);
        chk("rd_ren_cycles", ren_cyc, 1);
        chk("rd_stall_cycles", stall_cyc, 2);
        step();

        // Store, dhit in third ACCESS cycle; inputs change under a held access
        clr_counters();
        bus.dmemWEN_in   = 1'b1;
        bus.aluResult_in = 32'h0000_0080;
        bus.rdat2_in     = 32'h1234_5678;
        step();
        clr_req();
        bus.aluResult_in = 32'hFFFF_FFFC;
        bus.rdat2_in     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.dhit     = 1'b1;
                bus.dmemload = 32'hAAAA_AAAA;
            end
            @(negedge CLK);
            chk("st_dmemWEN", 32'(bus.dmemWEN), 1);
            chk("st_dmemaddr", bus.dmemaddr, 32'h0000_0080);
            chk("st_dmemstore", bus.dmemstore, 32'h1234_5678);
            step();
        end
        bus.dhit = 1'b0;
        @(negedge CLK);
        chk("st_wen_cycles", wen_cyc, 3);
        chk("st_ren_cycles", ren_cyc, 0);
        chk("st_stall_cycles", stall_cyc, 4);
        chk("st_access_count", 32'(bus.access_count), 2);
        chk("st_load_data_kept", bus.load_data, 32'hDEAD_BEEF);
        step();

        // Read that never sees dhit: abort after 4 ACCESS cycles
        clr_counters();
        bus.dmemREN_in   = 1'b1;
        bus.aluResult_in = 32'h0000_0100;
        bus.dmemload     = 32'hFFFF_FFFF;
        exp_q.push_back(32'h0);
        step();
        clr_req();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("to_dmemREN", 32'(bus.dmemREN), 1);
            if (i == 3) chk("to_err_before_abort", 32'(bus.timeout_err), 0);
            step();
        end
        @(negedge CLK);
        chk("to_timeout_err", 32'(bus.timeout_err), 1);
        chk("to_load_data", bus.load_data, 0);
        chk("to_access_count", 32'(bus.access_count), 2);
        chk("to_ren_cycles", ren_cyc, 4);
        step();
        // dhit while idle must do nothing
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h5555_5555;
        step();
        step();
        bus.dhit = 1'b0;
        @(negedge CLK);
        chk("idle_dhit_count", 32'(bus.access_count), 2);
        chk("to_err_sticky", 32'(bus.timeout_err), 1);
        chk("idle_dhit_load_data", bus.load_data, 0);

        // Read and write together: read wins
        step();
        clr_counters();
        bus.dmemREN_in   = 1'b1;
        bus.dmemWEN_in   = 1'b1;
        bus.aluResult_in = 32'h0000_0200;
        bus.rdat2_in     = 32'h0000_0099;
        exp_q.push_back(32'hCAFE_F00D);
        step();
        clr_req();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hCAFE_F00D;
        @(negedge CLK);
        chk("rw_dmemREN", 32'(bus.dmemREN), 1);
        chk("rw_dmemWEN", 32'(bus.dmemWEN), 0);
        step();
        bus.dhit = 1'b0;
        @(negedge CLK);
        chk("rw_wen_cycles", wen_cyc, 0);
        chk("rw_access_count", 32'(bus.access_count), 3);
        step();

        // Reset in the second ACCESS cycle
        bus.dmemREN_in   = 1'b1;
        bus.aluResult_in = 32'h0000_0300;
        step();
        clr_req();
        step();
        @(negedge CLK);
        chk("rstacc_dmemREN_before", 32'(bus.dmemREN), 1);
        nRST = 1'b0;
        step();
        @(negedge CLK);
        chk("rstacc_dmemREN", 32'(bus.dmemREN), 0);
        chk("rstacc_access_count", 32'(bus.access_count), 0);
        chk("rstacc_timeout_err", 32'(bus.timeout_err), 0);
        chk("rstacc_dmemaddr", bus.dmemaddr, 0);
        chk("rstacc_load_data", bus.load_data, 0);
        chk("rstacc_pipe_wen", 32'(bus.pipe_wen), 1);
        nRST = 1'b1;
        step();

        // Read with halt: completes, then HALTED absorbs further requests
        bus.dmemREN_in   = 1'b1;
        bus.halt_in      = 1'b1;
        bus.aluResult_in = 32'h0000_0044;
        exp_q.push_back(32'h0BAD_F00D);
        step();
        clr_req();
        bus.dhit     = 1'b1;
        bus.dmemload = 32'h0BAD_F00D;
        step();
        bus.dhit = 1'b0;
        step();
        @(negedge CLK);
        chk("halt_halt_out", 32'(bus.halt_out), 1);
        chk("halt_pipe_wen", 32'(bus.pipe_wen), 0);
        chk("halt_access_count", 32'(bus.access_count), 1);
        clr_counters();
        bus.dmemREN_in = 1'b1;
        bus.dhit       = 1'b1;
        repeat (3) step();
        clr_req();
        bus.dhit = 1'b0;
        @(negedge CLK);
        chk("halt_ren_cycles", ren_cyc, 0);
        chk("halt_count_frozen", 32'(bus.access_count), 1);
        chk("halt_sticky", 32'(bus.halt_out), 1);

        // Halt with no request goes straight to HALTED
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        bus.halt_in = 1'b1;
        @(negedge CLK);
        chk("idlehalt_pipe_wen", 32'(bus.pipe_wen), 1);
        step();
        bus.halt_in = 1'b0;
        @(negedge CLK);
        chk("idlehalt_halt_out", 32'(bus.halt_out), 1);

        step();
        chk("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
